// File: rtl/dds_increment_slewer.sv
// dds_increment_slewer: slews the DDS phase increment toward a requested target
// in bounded steps with a programmable dwell, freezing while the MMCM is unlocked.
//   clk_ref, clk_ref_aresetn       : clock and asynchronous active-low reset
//   target_increment, step_size,
//   dwell_cycles, target_valid,
//   target_ready                   : request handshake (accepted only in IDLE)
//   abort                          : stop the ramp at the current value
//   pll_locked                     : raw MMCM LOCKED, synchronized here
//   increment, busy, done,
//   unlock_count                   : registered status and DDS increment
module dds_increment_slewer #(
   parameter logic [31:0] DEFAULT_INCREMENT = 32'h33333333,
   parameter int          DWELL_WIDTH       = 16,
   parameter int          RELOCK_SETTLE     = 1024
) (
   input  logic                   clk_ref,
   input  logic                   clk_ref_aresetn,
   input  logic [31:0]            target_increment,
   input  logic [31:0]            step_size,
   input  logic [DWELL_WIDTH-1:0] dwell_cycles,
   input  logic                   target_valid,
   output logic                   target_ready,
   input  logic                   abort,
   input  logic                   pll_locked,
   output logic [31:0]            increment,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            unlock_count
);
   localparam int SW = $clog2(RELOCK_SETTLE + 1);

   typedef enum logic [1:0] {IDLE, STEP, DWELL, HOLD} state_t;

   state_t                 state, state_nx;
   logic [31:0]            tgt, tgt_nx, stp, stp_nx, inc_nx, diff;
   logic [DWELL_WIDTH-1:0] dwl, dwl_nx, cnt, cnt_nx;
   logic [SW-1:0]          settle, settle_nx;
   logic [15:0]            unl_nx;
   logic                   sync1, lock_s, done_nx, accept;

   assign accept = target_valid & target_ready;
   assign diff   = (tgt > increment) ? tgt - increment : increment - tgt;

   always_ff @(posedge clk_ref or negedge clk_ref_aresetn) begin
      if (!clk_ref_aresetn) begin
         state        <= IDLE;
         increment    <= DEFAULT_INCREMENT;
         tgt          <= DEFAULT_INCREMENT;
         stp          <= '0;
         dwl          <= '0;
         cnt          <= '0;
         settle       <= '0;
         unlock_count <= '0;
         done         <= 1'b0;
         busy         <= 1'b0;
         target_ready <= 1'b1;
         sync1        <= 1'b0;
         lock_s       <= 1'b0;
      end else begin
         state        <= state_nx;
         increment    <= inc_nx;
         tgt          <= tgt_nx;
         stp          <= stp_nx;
         dwl          <= dwl_nx;
         cnt          <= cnt_nx;
         settle       <= settle_nx;
         unlock_count <= unl_nx;
         done         <= done_nx;
         busy         <= state_nx != IDLE;
         target_ready <= state_nx == IDLE;
         sync1        <= pll_locked;
         lock_s       <= sync1;
      end
   end

   // abort outranks lock loss, which outranks the dwell exit
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (accept && target_increment != increment) ? STEP : IDLE;
         STEP:    state_nx = abort ? IDLE : !lock_s ? HOLD : DWELL;
         DWELL:   state_nx = abort ? IDLE : !lock_s ? HOLD : (cnt != '0) ? DWELL :
                             (increment == tgt) ? IDLE : STEP;
         HOLD:    state_nx = abort ? IDLE :
                             (lock_s && settle == SW'(RELOCK_SETTLE - 1)) ? DWELL : HOLD;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      tgt_nx    = tgt;
      stp_nx    = stp;
      dwl_nx    = dwl;
      inc_nx    = increment;
      cnt_nx    = cnt;
      settle_nx = settle;
      unl_nx    = unlock_count;
      done_nx   = 1'b0;
      if (state == IDLE && accept) begin
         tgt_nx  = target_increment;
         stp_nx  = step_size;
         dwl_nx  = dwell_cycles;
         done_nx = target_increment == increment;
      end
      // the step only lands when STEP proceeds to DWELL, so lock loss suppresses it
      if (state == STEP && state_nx == DWELL) begin
         inc_nx = (stp == '0 || diff <= stp) ? tgt :
                  (tgt > increment) ? increment + stp : increment - stp;
         cnt_nx = dwl;
      end
      if (state == DWELL && state_nx == DWELL)
         cnt_nx = cnt - 1'b1;
      if (state == DWELL && state_nx == IDLE && !abort)
         done_nx = 1'b1;
      if (state == HOLD) begin
         settle_nx = lock_s ? settle + SW'(1) : '0;
         if (state_nx == DWELL)
            cnt_nx = dwl;
      end
      if (state != HOLD && state_nx == HOLD) begin
         settle_nx = '0;
         unl_nx    = (unlock_count == 16'hFFFF) ? unlock_count : unlock_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_dds_increment_slewer.sv
// tb_dds_increment_slewer: directed ramps with a scoreboard of expected increment/done events.
module tb_dds_increment_slewer;
   localparam logic [31:0] DEF  = 32'h33333333;
   localparam logic [31:0] DTAG = 32'hDDDDDDDD;

   logic        clk_ref = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] target_increment = '0;
   logic [31:0] step_size = '0;
   logic [15:0] dwell_cycles = '0;
   logic        target_valid = 1'b0;
   logic        target_ready;
   logic        abort = 1'b0;
   logic        pll_locked = 1'b1;
   logic [31:0] increment;
   logic        busy;
   logic        done;
   logic [15:0] unlock_count;

   dds_increment_slewer #(.RELOCK_SETTLE(16)) dut (
      .clk_ref(clk_ref), .clk_ref_aresetn(rst_n),
      .target_increment(target_increment), .step_size(step_size),
      .dwell_cycles(dwell_cycles), .target_valid(target_valid),
      .target_ready(target_ready), .abort(abort), .pll_locked(pll_locked),
      .increment(increment), .busy(busy), .done(done), .unlock_count(unlock_count)
   );

   always #5 clk_ref = ~clk_ref;

   typedef struct {logic is_done; logic [31:0] val; int gap;} evt_t;
   evt_t        q[$];
   evt_t        e;
   int          n_pass = 0, n_total = 0, cyc = 0, last_cyc = 0;
   logic [31:0] prev_inc = DEF;

   always @(posedge clk_ref) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic void exp_inc(input logic [31:0] v, input int g);
      q.push_back('{1'b0, v, g});
   endfunction

   function automatic void exp_done(input int g);
      q.push_back('{1'b1, DTAG, g});
   endfunction

   // monitor: every increment change or done pulse must match the queue head
   always @(negedge clk_ref) begin
      if (done || increment !== prev_inc) begin
         if (q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got done=%0b inc=0x%08h, expected no event", done, increment);
         end else begin
            e = q.pop_front();
            chk(e.is_done ? "done_event" : "inc_event", done ? DTAG : increment, e.val);
            if (e.gap != 0) chk("event_gap", 32'(cyc - last_cyc), 32'(e.gap));
            if (e.is_done) chk("busy_with_done", 32'(busy), 32'd0);
         end
         last_cyc = cyc;
         prev_inc = increment;
      end
   end

   task automatic request(input logic [31:0] t, input logic [31:0] s, input logic [15:0] d);
      @(negedge clk_ref);
      target_increment = t;
      step_size        = s;
      dwell_cycles     = d;
      target_valid     = 1'b1;
      @(negedge clk_ref);
      target_valid     = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk_ref);
         n++;
      end
      chk(name, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1);
   end

   initial begin
      @(negedge clk_ref);
      chk("rst_increment", increment, DEF);
      chk("rst_ready", 32'(target_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_unlock", 32'(unlock_count), 32'd0);
      @(negedge clk_ref);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_ref);

      // up-ramp with an ignored mid-ramp request
      exp_inc(32'h33333337, 0);
      exp_inc(32'h3333333B, 5);
      exp_inc(32'h3333333F, 5);
      exp_inc(32'h33333340, 5);
      exp_done(4);
      request(32'h33333340, 32'd4, 16'd3);
      chk("ramp_busy", 32'(busy), 32'd1);
      chk("ramp_ready", 32'(target_ready), 32'd0);
      repeat (6) @(negedge clk_ref);
      request(32'h00000000, 32'd0, 16'd0);
      wait_idle("up_idle");
      chk("up_final", increment, 32'h33333340);

      exp_inc(DEF, 0);
      exp_done(1);
      request(DEF, 32'd0, 16'd0);
      wait_idle("back_idle");

      // down-ramp: step larger than distance lands exactly on target
      exp_inc(32'h33333330, 0);
      exp_done(1);
      request(32'h33333330, 32'h10, 16'd0);
      wait_idle("down_idle");
      chk("down_final", increment, 32'h33333330);

      // direct jump, then a no-op request
      exp_inc(32'h40000000, 0);
      exp_done(6);
      request(32'h40000000, 32'd0, 16'd5);
      wait_idle("jump_idle");
      exp_done(0);
      request(32'h40000000, 32'd0, 16'd0);
      chk("noop_done", 32'(done), 32'd1);
      chk("noop_busy", 32'(busy), 32'd0);
      @(negedge clk_ref);
      chk("noop_busy2", 32'(busy), 32'd0);

      // lock loss mid-dwell plus a glitch during settle
      exp_inc(32'h40000004, 0);
      exp_inc(32'h40000008, 5);
      exp_inc(32'h4000000C, 40);
      exp_inc(32'h40000010, 5);
      exp_done(4);
      request(32'h40000010, 32'd4, 16'd3);
      repeat (6) @(negedge clk_ref);
      pll_locked = 1'b0;
      repeat (10) @(negedge clk_ref);
      pll_locked = 1'b1;
      chk("hold_unlock", 32'(unlock_count), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_frozen", increment, 32'h40000008);
      repeat (6) @(negedge clk_ref);
      pll_locked = 1'b0;
      @(negedge clk_ref);
      pll_locked = 1'b1;
      wait_idle("lock_idle");
      chk("lock_unlock_final", 32'(unlock_count), 32'd1);

      // asynchronous reset mid-ramp
      exp_inc(32'h40000110, 0);
      exp_inc(DEF, 0);
      request(32'h40001000, 32'h100, 16'd2);
      repeat (2) @(negedge clk_ref);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_inc", increment, DEF);
      @(negedge clk_ref);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_unlock", 32'(unlock_count), 32'd0);
      @(negedge clk_ref);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_ref);

      // abort mid-ramp
      exp_inc(32'h33333337, 0);
      exp_inc(32'h3333333B, 5);
      request(32'h33333340, 32'd4, 16'd3);
      repeat (6) @(negedge clk_ref);
      abort = 1'b1;
      @(negedge clk_ref);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(target_ready), 32'd1);
      chk("abort_inc", increment, 32'h3333333B);
      chk("abort_done", 32'(done), 32'd0);
      repeat (6) @(negedge clk_ref);

      // abort coinciding with the final dwell exit
      exp_inc(32'h3333333C, 0);
      request(32'h3333333C, 32'd4, 16'd2);
      repeat (3) @(negedge clk_ref);
      abort = 1'b1;
      @(negedge clk_ref);
      abort = 1'b0;
      chk("abort_exit_done", 32'(done), 32'd0);
      chk("abort_exit_busy", 32'(busy), 32'd0);
      chk("abort_exit_inc", increment, 32'h3333333C);
      repeat (5) @(negedge clk_ref);

      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
